pwm_voice_scheduler: RTL and testbench
======================================

# pwm_voice_scheduler

Round-robin scheduler that shares the single phase_generator → sine lookup → pwm voice path between several note requesters. Each requester asks to play one note, given as a phase delta and a duration counted in sample ticks. The scheduler grants one requester at a time and loads that note's phase delta into phase_generator. It then holds the note for its duration, mutes the voice, and inserts a fixed articulation gap before serving the next requester. It sits between the note sources (sequencers, button handlers) and phase_generator's i_phase_delta/i_phase_delta_valid inputs.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- PD_W, 32, phase delta width
- DUR_W, 16, duration width in ticks
- GAP_TICKS, 2, silent ticks between notes (0 = no gap)

- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous, active-low reset
- i_tick  in  1  single-cycle duration time-base strobe
- i_req  in  NUM_REQ  level request per requester
- i_phase_delta  in  NUM_REQ*PD_W  packed deltas; requester r occupies [r*PD_W +: PD_W]
- i_duration  in  NUM_REQ*DUR_W  packed durations, same packing
- o_grant  out  NUM_REQ  one-hot, one-cycle grant pulse
- o_done  out  1  one-cycle pulse at note end
- o_done_id  out  $clog2(NUM_REQ)  index of the finished requester, valid while o_done is high
- o_phase_delta  out  PD_W  phase delta for phase_generator
- o_phase_delta_valid  out  1  one-cycle load strobe
- o_gate  out  1  high while a note sounds
- o_busy  out  1  high whenever state ≠ IDLE

## Operation
- States: IDLE, PLAY, GAP.
- All outputs are registered.

**IDLE**
- If any i_req bit is set, select the first set bit at or cyclically after the pointer rr (reset value 0).
- In the same edge:
  - capture that requester's delta and duration;
  - drive o_grant with the winner's one-hot bit;
  - set rr = (winner + 1) mod NUM_REQ;
  - clear the tick counter.
- Duration ≠ 0:
  - o_phase_delta ← captured delta, o_phase_delta_valid = 1, o_gate = 1;
  - next state PLAY.
- Duration = 0 (rest):
  - o_done = 1 together with the grant;
  - no valid strobe, o_gate stays 0;
  - next state is GAP, or IDLE when GAP_TICKS = 0.

**PLAY**
- The counter increments on each i_tick.
- On the i_tick that brings the count to the captured duration:
  - o_gate = 0, o_phase_delta ← 0, o_phase_delta_valid = 1 (mute);
  - o_done = 1 and o_done_id = winner;
  - next state GAP (or IDLE if GAP_TICKS = 0).
- The counter is cleared on exit.

**GAP**
- Count GAP_TICKS ticks, then return to IDLE.

**Request handling**
- The captured delta and duration are stable for the whole note.
- i_req, i_phase_delta and i_duration are ignored outside IDLE.
- A requester may drop i_req any time after its grant.
- A request still high when the scheduler returns to IDLE competes again; the round-robin pointer prevents starvation.

**Width and range rules**
- The counter is DUR_W bits wide and never wraps: the terminal compare is exact, so the maximum duration is 2^DUR_W − 1 ticks.
- The gap counter is $clog2(GAP_TICKS+1) bits.

## Timing
- Reset (asynchronous, immediate):
  - state IDLE, rr = 0, counters 0;
  - o_grant = 0, o_done = 0, o_done_id = 0, o_phase_delta = 0, o_phase_delta_valid = 0, o_gate = 0, o_busy = 0.
- Asserting reset mid-note silences the voice immediately, because o_gate and o_phase_delta clear. No o_done pulse is issued.
- Request-to-output latency: a request sampled at edge N produces o_grant, o_phase_delta_valid and o_gate = 1 after edge N.
- An i_tick coincident with the grant edge is not counted; counting starts the cycle after entry to PLAY (likewise for GAP).
- A note of duration D lasts exactly D i_tick strobes. o_gate falls on the edge that samples the D-th tick.
- A new grant is issued no earlier than the cycle after GAP ends, i.e. after GAP_TICKS further ticks.
- With GAP_TICKS = 0, the next grant comes on the cycle after o_done.
- o_grant, o_done and o_phase_delta_valid are never high for more than one cycle. Outside PLAY, o_phase_delta is 0 except in the load cycle.

## Test plan
- **Reset values.** Hold i_rst_n = 0 with i_req = 4'b1111. Expect all outputs 0 and no grant. Release reset; expect o_grant = 4'b0001 one cycle later.
- **Single note.** req[2] with delta 75_591 and duration 3, i_tick every 10 clocks, GAP_TICKS = 2:
  - one o_phase_delta_valid with 75_591;
  - o_gate high for exactly 3 ticks;
  - mute strobe with 0, o_done with o_done_id = 2;
  - o_busy drops after 2 further ticks.
- **Round-robin.** i_req = 4'b1011 held, all durations 1. Expect grant order 0, 1, 3, 0, 1, 3.
- **Zero duration.** req[1] with duration 0. Expect o_grant = 4'b0010 and o_done in the same cycle, with no o_phase_delta_valid and o_gate never high.
- **Input stability.** Change i_phase_delta and i_duration of the granted requester during PLAY. Expect the captured delta and duration to be unaffected.
- **Reset mid-note.** Pulse i_rst_n low during PLAY. Expect o_gate = 0 and o_phase_delta = 0 asynchronously, no o_done, and rr back to 0.

Source files
------------

// File: rtl/pwm_voice_scheduler.sv
// pwm_voice_scheduler: round-robin note scheduler feeding phase_generator (req/delta/duration in; grant, done, delta load strobe, gate, busy out)
module pwm_voice_scheduler #(
  parameter int NUM_REQ   = 4,
  parameter int PD_W      = 32,
  parameter int DUR_W     = 16,
  parameter int GAP_TICKS = 2
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_tick,
  input  logic [NUM_REQ-1:0]         i_req,
  input  logic [NUM_REQ*PD_W-1:0]    i_phase_delta,
  input  logic [NUM_REQ*DUR_W-1:0]   i_duration,
  output logic [NUM_REQ-1:0]         o_grant,
  output logic                       o_done,
  output logic [$clog2(NUM_REQ)-1:0] o_done_id,
  output logic [PD_W-1:0]            o_phase_delta,
  output logic                       o_phase_delta_valid,
  output logic                       o_gate,
  output logic                       o_busy
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int GW = GAP_TICKS > 0 ? $clog2(GAP_TICKS + 1) : 1;
  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;
  state_t state, state_n;
  logic [IW-1:0] rr, rr_n, id_q, id_n, done_id_n;
  logic [DUR_W-1:0] cnt, cnt_n, dur_q, dur_n, cnt_inc, dur_sel;
  logic [GW-1:0] gcnt, gcnt_n, gcnt_inc;
  logic [NUM_REQ-1:0] grant_n;
  logic [PD_W-1:0] pd_n;
  logic done_n, pdv_n, gate_n, found;
  int win;
  assign cnt_inc  = cnt + DUR_W'(1);
  assign gcnt_inc = gcnt + GW'(1);
  assign dur_sel  = i_duration[win*DUR_W +: DUR_W];
  always_comb begin
    found = 1'b0;
    win = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && i_req[(int'(rr) + i) % NUM_REQ]) begin
        found = 1'b1;
        win = (int'(rr) + i) % NUM_REQ;
      end
    end
  end
  always_comb begin
    state_n   = state;
    rr_n      = rr;
    id_n      = id_q;
    cnt_n     = cnt;
    dur_n     = dur_q;
    gcnt_n    = gcnt;
    grant_n   = '0;
    done_n    = 1'b0;
    done_id_n = o_done_id;
    pd_n      = o_phase_delta;
    pdv_n     = 1'b0;
    gate_n    = o_gate;
    case (state)
      IDLE: if (found) begin
        grant_n = NUM_REQ'(1) << win;
        rr_n    = IW'((win + 1) % NUM_REQ);
        id_n    = IW'(win);
        cnt_n   = '0;
        gcnt_n  = '0;
        dur_n   = dur_sel;
        if (dur_sel != '0) begin
          pd_n    = i_phase_delta[win*PD_W +: PD_W];
          pdv_n   = 1'b1;
          gate_n  = 1'b1;
          state_n = PLAY;
        end else begin
          done_n    = 1'b1;
          done_id_n = IW'(win);
          state_n   = GAP_TICKS > 0 ? GAP : IDLE;
        end
      end
      PLAY: if (i_tick) begin
        cnt_n = cnt_inc;
        if (cnt_inc == dur_q) begin
          gate_n    = 1'b0;
          pd_n      = '0;
          pdv_n     = 1'b1;
          done_n    = 1'b1;
          done_id_n = id_q;
          cnt_n     = '0;
          gcnt_n    = '0;
          state_n   = GAP_TICKS > 0 ? GAP : IDLE;
        end
      end
      GAP: if (i_tick) begin
        gcnt_n = gcnt_inc;
        if (gcnt_inc == GW'(GAP_TICKS)) begin
          gcnt_n  = '0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state               <= IDLE;
      rr                  <= '0;
      id_q                <= '0;
      cnt                 <= '0;
      dur_q               <= '0;
      gcnt                <= '0;
      o_grant             <= '0;
      o_done              <= 1'b0;
      o_done_id           <= '0;
      o_phase_delta       <= '0;
      o_phase_delta_valid <= 1'b0;
      o_gate              <= 1'b0;
      o_busy              <= 1'b0;
    end else begin
      state               <= state_n;
      rr                  <= rr_n;
      id_q                <= id_n;
      cnt                 <= cnt_n;
      dur_q               <= dur_n;
      gcnt                <= gcnt_n;
      o_grant             <= grant_n;
      o_done              <= done_n;
      o_done_id           <= done_id_n;
      o_phase_delta       <= pd_n;
      o_phase_delta_valid <= pdv_n;
      o_gate              <= gate_n;
      o_busy              <= state_n != IDLE;
    end
  end
endmodule

// File: tb/tb_pwm_voice_scheduler.sv
// tb_pwm_voice_scheduler: self-checking bench for pwm_voice_scheduler
module tb_pwm_voice_scheduler;
  localparam int N = 4, PW = 32, DW = 16, GAP = 2;
  logic clk = 0, rst_n = 0, tick = 0;
  logic [N-1:0] req = '0;
  logic [N*PW-1:0] pd = '0;
  logic [N*DW-1:0] dur = '0;
  logic [N-1:0] grant;
  logic done, pdv, gate, busy;
  logic [1:0] done_id;
  logic [PW-1:0] opd;
  int total = 0, bad = 0;
  int m_mode, m_ptr, m_left, m_gap, m_id;
  logic [3:0] e_grant;
  logic [1:0] e_id;
  logic [31:0] e_pd;
  logic e_done, e_pdv, e_gate, e_busy;
  typedef struct { logic [3:0] req; int d; logic [3:0] g; bit rest; } vec_t;
  vec_t tbl[11];

  pwm_voice_scheduler #(.NUM_REQ(N), .PD_W(PW), .DUR_W(DW), .GAP_TICKS(GAP)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_tick(tick), .i_req(req),
    .i_phase_delta(pd), .i_duration(dur), .o_grant(grant), .o_done(done),
    .o_done_id(done_id), .o_phase_delta(opd), .o_phase_delta_valid(pdv),
    .o_gate(gate), .o_busy(busy));

  always #5 clk = ~clk;

  function automatic void m_reset();
    m_mode = 0; m_ptr = 0; m_left = 0; m_gap = 0; m_id = 0;
    e_grant = 0; e_done = 0; e_id = 0; e_pd = 0; e_pdv = 0; e_gate = 0; e_busy = 0;
  endfunction

  function automatic void m_step();
    int w;
    e_grant = 0; e_done = 0; e_pdv = 0;
    if (m_mode == 0) begin
      w = -1;
      for (int k = N - 1; k >= 0; k--) if (req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
      if (w >= 0) begin
        e_grant = 4'(1 << w);
        m_ptr = (w + 1) % N;
        m_id = w;
        if (dur[w*DW +: DW] != 0) begin
          m_left = int'(dur[w*DW +: DW]);
          e_pd = pd[w*PW +: PW]; e_pdv = 1; e_gate = 1; m_mode = 1;
        end else begin
          e_done = 1; e_id = 2'(w); m_mode = GAP > 0 ? 2 : 0; m_gap = GAP;
        end
      end
    end else if (m_mode == 1) begin
      if (tick) begin
        m_left--;
        if (m_left == 0) begin
          e_gate = 0; e_pd = 0; e_pdv = 1; e_done = 1; e_id = 2'(m_id);
          m_mode = GAP > 0 ? 2 : 0; m_gap = GAP;
        end
      end
    end else if (tick) begin
      m_gap--;
      if (m_gap == 0) m_mode = 0;
    end
    e_busy = m_mode != 0;
  endfunction

  task automatic check(string nm, logic [63:0] a, logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, a, e, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    if (!rst_n) m_reset(); else m_step();
    @(negedge clk);
    check("model", {grant, done, opd, pdv, gate, busy}, {e_grant, e_done, e_pd, e_pdv, e_gate, e_busy});
    if (e_done) check("model_id", done_id, e_id);
  endtask

  task automatic drain();
    for (int c = 0; c < 400 && busy; c++) begin
      tick = (c % 2) == 1;
      cyc();
    end
    tick = 0;
    check("drain_idle", busy, 0);
  endtask

  task automatic set_dur(int d);
    for (int r = 0; r < N; r++) dur[r*DW +: DW] = 16'(d);
  endtask

  initial begin
    int seen;
    bit got;
    m_reset();
    tbl[0]  = '{4'b1011, 1, 4'b0001, 0};
    tbl[1]  = '{4'b1011, 1, 4'b0010, 0};
    tbl[2]  = '{4'b1011, 1, 4'b1000, 0};
    tbl[3]  = '{4'b1011, 1, 4'b0001, 0};
    tbl[4]  = '{4'b1011, 1, 4'b0010, 0};
    tbl[5]  = '{4'b1011, 1, 4'b1000, 0};
    tbl[6]  = '{4'b0010, 0, 4'b0010, 1};
    tbl[7]  = '{4'b1111, 0, 4'b0100, 1};
    tbl[8]  = '{4'b0011, 2, 4'b0001, 0};
    tbl[9]  = '{4'b1100, 1, 4'b0100, 0};
    tbl[10] = '{4'b1001, 1, 4'b1000, 0};
    req = 4'b1111;
    set_dur(1);
    repeat (3) cyc();
    check("reset_outs", {grant, done, done_id, opd, pdv, gate, busy}, 0);
    rst_n = 1;
    cyc();
    check("first_grant", grant, 4'b0001);
    req = 0;
    drain();
    pd[2*PW +: PW] = 75591;
    dur[2*DW +: DW] = 3;
    req = 4'b0100;
    cyc();
    check("note_grant", grant, 4'b0100);
    check("note_load", {pdv, gate, opd}, {1'b1, 1'b1, 32'd75591});
    req = 0;
    seen = 0; got = 0;
    for (int c = 0; c < 300 && !got; c++) begin
      tick = (c % 10) == 9;
      cyc();
      if (tick) seen++;
      if (done) got = 1;
    end
    tick = 0;
    check("note_done_seen", got, 1);
    check("note_ticks", seen, 3);
    check("note_mute", {done_id, pdv, gate, opd}, {2'd2, 1'b1, 1'b0, 32'd0});
    seen = 0;
    for (int c = 0; c < 300 && busy; c++) begin
      tick = (c % 10) == 9;
      cyc();
      if (tick) seen++;
    end
    tick = 0;
    check("gap_ticks", seen, 2);
    check("gap_idle", busy, 0);
    rst_n = 0;
    cyc();
    rst_n = 1;
    for (int i = 0; i < 11; i++) begin
      pd = {$urandom, $urandom, $urandom, $urandom};
      set_dur(tbl[i].d);
      req = tbl[i].req;
      cyc();
      check($sformatf("tbl%0d_grant", i), grant, tbl[i].g);
      check($sformatf("tbl%0d_flags", i), {done, pdv, gate}, {tbl[i].rest, !tbl[i].rest, !tbl[i].rest});
      req = 0;
      drain();
    end
    pd[0 +: PW] = 1234;
    dur[0 +: DW] = 4;
    req = 4'b0001;
    cyc();
    check("stab_load", opd, 1234);
    req = 0;
    pd[0 +: PW] = 999;
    dur[0 +: DW] = 1;
    cyc();
    check("stab_pd", opd, 1234);
    seen = 0; got = 0;
    for (int c = 0; c < 100 && !got; c++) begin
      tick = (c % 2) == 1;
      cyc();
      if (tick) seen++;
      if (done) got = 1;
    end
    tick = 0;
    check("stab_ticks", seen, 4);
    drain();
    set_dur(5);
    req = 4'b0100;
    cyc();
    check("mid_grant", grant, 4'b0100);
    req = 0;
    for (int c = 0; c < 4; c++) begin
      tick = (c % 2) == 1;
      cyc();
    end
    tick = 0;
    #2 rst_n = 0;
    m_reset();
    #1 check("async_reset", {grant, done, opd, pdv, gate, busy}, 0);
    cyc();
    rst_n = 1;
    req = 4'b1100;
    cyc();
    check("rr_after_reset", grant, 4'b0100);
    req = 0;
    drain();
    for (int c = 0; c < 3000; c++) begin
      tick = ($urandom % 3) == 0;
      if ($urandom % 4 == 0) req = 4'($urandom);
      for (int r = 0; r < N; r++) begin
        pd[r*PW +: PW] = $urandom;
        dur[r*DW +: DW] = 16'($urandom % 6);
      end
      if ($urandom % 700 == 0) begin
        rst_n = 0;
        m_reset();
        cyc();
        rst_n = 1;
      end
      cyc();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
